// File: rtl/text_buf_ctrl.sv
// rtl/text_buf_ctrl.sv - keyboard-to-character-RAM text buffer controller with hardware scroll
`timescale 1ns/1ps

module text_buf_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  output logic        mem_we,
  output logic [11:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  input  logic [4:0]  rd_row,
  input  logic [6:0]  rd_col,
  output logic [11:0] mem_raddr,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  localparam int TOTAL = ROWS * COLS;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [6:0]  cur_col_q, cur_col_d;
  logic [4:0]  top_row_q, top_row_d;
  logic [12:0] init_cnt_q, init_cnt_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic        scroll_q, scroll_d;
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        key_ready_q, key_ready_d;
  logic        clear_go;
  logic        accept;

  // Logical row to physical row; the sum is kept one bit wider so it never wraps.
  function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [11:0] lin_addr(input logic [4:0] prow, input logic [6:0] col);
    return 12'(prow) * 12'(COLS) + 12'(col);
  endfunction

  assign accept    = key_valid && key_ready_q;
  assign key_ready = key_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;

  // Display-side read address translation, out-of-range requests map to 0.
  always_comb begin
    mem_raddr = '0;
    if ((32'(rd_row) < ROWS) && (32'(rd_col) < COLS))
      mem_raddr = lin_addr(phys_row(rd_row, top_row_q), rd_col);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    top_row_d   = top_row_q;
    init_cnt_d  = init_cnt_q;
    clr_col_d   = clr_col_q;
    scroll_d    = scroll_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    key_ready_d = 1'b0;
    clear_go    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q < 13'(TOTAL)) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = init_cnt_q[11:0];
          mem_wdata_d = 8'h20;
          init_cnt_d  = init_cnt_q + 13'd1;
        end else begin
          state_d     = S_IDLE;
          key_ready_d = 1'b1;
        end
      end

      S_IDLE: begin
        key_ready_d = 1'b1;
        if (accept) begin
          if ((key_ascii >= 8'h20) && (key_ascii <= 8'h7E)) begin
            // Printable: write at cursor, advance cursor on this same edge.
            mem_we_d    = 1'b1;
            mem_waddr_d = lin_addr(phys_row(cur_row_q, top_row_q), cur_col_q);
            mem_wdata_d = key_ascii;
            key_ready_d = 1'b0;
            state_d     = S_WRITE;
            if (cur_col_q == 7'(COLS - 1)) begin
              cur_col_d = '0;
              if (cur_row_q == 5'(ROWS - 1)) scroll_d = 1'b1;
              else cur_row_d = cur_row_q + 5'd1;
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end else if (key_ascii == 8'h0D) begin
            cur_col_d = '0;
            if (cur_row_q == 5'(ROWS - 1)) begin
              key_ready_d = 1'b0;
              clear_go    = 1'b1;
            end else begin
              cur_row_d = cur_row_q + 5'd1;
            end
          end else if (key_ascii == 8'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d   = cur_col_q - 7'd1;
              mem_we_d    = 1'b1;
              mem_waddr_d = lin_addr(phys_row(cur_row_q, top_row_q), cur_col_q - 7'd1);
              mem_wdata_d = 8'h20;
              key_ready_d = 1'b0;
              state_d     = S_WRITE;
            end else if (cur_row_q != '0) begin
              cur_row_d   = cur_row_q - 5'd1;
              cur_col_d   = 7'(COLS - 1);
              mem_we_d    = 1'b1;
              mem_waddr_d = lin_addr(phys_row(cur_row_q - 5'd1, top_row_q), 7'(COLS - 1));
              mem_wdata_d = 8'h20;
              key_ready_d = 1'b0;
              state_d     = S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        if (scroll_q) begin
          scroll_d = 1'b0;
          clear_go = 1'b1;
        end else begin
          state_d     = S_IDLE;
          key_ready_d = 1'b1;
        end
      end

      S_CLEAR: begin
        if (clr_col_q == 7'(COLS - 1)) begin
          // Last blanking write is on the bus now; the cleared row becomes the bottom row.
          state_d     = S_IDLE;
          key_ready_d = 1'b1;
          top_row_d   = (top_row_q == 5'(ROWS - 1)) ? '0 : top_row_q + 5'd1;
          cur_row_d   = 5'(ROWS - 1);
          cur_col_d   = '0;
        end else begin
          clr_col_d   = clr_col_q + 7'd1;
          mem_we_d    = 1'b1;
          mem_waddr_d = lin_addr(top_row_q, clr_col_q + 7'd1);
          mem_wdata_d = 8'h20;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    if (clear_go) begin
      state_d     = S_CLEAR;
      clr_col_d   = '0;
      mem_we_d    = 1'b1;
      mem_waddr_d = lin_addr(top_row_q, 7'd0);
      mem_wdata_d = 8'h20;
    end
  end

  // State register with synchronous reset; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      top_row_q   <= '0;
      init_cnt_q  <= '0;
      clr_col_q   <= '0;
      scroll_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      top_row_q   <= top_row_d;
      init_cnt_q  <= init_cnt_d;
      clr_col_q   <= clr_col_d;
      scroll_q    <= scroll_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      key_ready_q <= key_ready_d;
    end
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// tb/tb_text_buf_ctrl.sv - randomized self-checking bench for text_buf_ctrl
`timescale 1ns/1ps

module tb_text_buf_ctrl;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        key_ready;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [4:0]  rd_row = 5'd0;
  logic [6:0]  rd_col = 7'd0;
  logic [11:0] mem_raddr;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  text_buf_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ascii(key_ascii),
    .key_ready(key_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .rd_row(rd_row), .rd_col(rd_col),
    .mem_raddr(mem_raddr), .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;
  int obs_addr[$];
  int obs_data[$];
  int obs_cyc[$];
  int exp_addr[$];
  int exp_data[$];

  // Reference model: linear logical cursor position and screen top row.
  int mdl_pos = 0;
  int mdl_top = 0;

  // Write monitor: logs every write seen on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(int'(mem_waddr));
      obs_data.push_back(int'(mem_wdata));
      obs_cyc.push_back(cyc);
      if (key_ready === 1'b1) overlap = overlap + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int mdl_phys(input int lrow, input int col);
    return ((lrow + mdl_top) % ROWS) * COLS + col;
  endfunction

  function automatic void mdl_scroll();
    for (int c = 0; c < COLS; c++) begin
      exp_addr.push_back(mdl_top * COLS + c);
      exp_data.push_back(32);
    end
    mdl_top = (mdl_top + 1) % ROWS;
    mdl_pos = (ROWS - 1) * COLS;
  endfunction

  function automatic void mdl_key(input int code);
    if (code >= 32 && code <= 126) begin
      exp_addr.push_back(mdl_phys(mdl_pos / COLS, mdl_pos % COLS));
      exp_data.push_back(code);
      mdl_pos = mdl_pos + 1;
      if (mdl_pos == TOTAL) mdl_scroll();
    end else if (code == 13) begin
      mdl_pos = (mdl_pos / COLS + 1) * COLS;
      if (mdl_pos == TOTAL) mdl_scroll();
    end else if (code == 8) begin
      if (mdl_pos > 0) begin
        mdl_pos = mdl_pos - 1;
        exp_addr.push_back(mdl_phys(mdl_pos / COLS, mdl_pos % COLS));
        exp_data.push_back(32);
      end
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    overlap = 0;
  endtask

  // Send one code, collect the writes it causes and compare with the model.
  task automatic send_key(input int code, input string name);
    int n;
    int bad;
    n = 0;
    while (key_ready !== 1'b1 && n < 300) begin step(); n++; end
    clear_logs();
    key_valid = 1'b1;
    key_ascii = 8'(code);
    step();
    key_valid = 1'b0;
    mdl_key(code);
    n = 0;
    while (key_ready !== 1'b1 && n < 300) begin step(); n++; end
    vectors++;
    if (key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_timeout: key_ready=%b required 1", name, key_ready);
    end
    vectors++;
    bad = 0;
    if (obs_addr.size() != exp_addr.size()) bad = 1;
    else for (int i = 0; i < exp_addr.size(); i++)
      if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) bad++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s writes: got %0d writes (first %0d/%0h) required %0d writes (first %0d/%0h)",
               name, obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1,
               (obs_data.size() > 0) ? obs_data[0] : -1, exp_addr.size(),
               (exp_addr.size() > 0) ? exp_addr[0] : -1, (exp_data.size() > 0) ? exp_data[0] : -1);
    end
    vectors++;
    if (int'(cur_row) !== mdl_pos / COLS || int'(cur_col) !== mdl_pos % COLS) begin
      miscompares++;
      $display("FAIL %s cursor: got (%0d,%0d) required (%0d,%0d)", name, cur_row, cur_col,
               mdl_pos / COLS, mdl_pos % COLS);
    end
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL %s ready_during_write: %0d cycles with key_ready and mem_we, required 0", name, overlap);
    end
  endtask

  task automatic check_raddr(input int r, input int c, input int expv, input string name);
    rd_row = 5'(r);
    rd_col = 7'(c);
    #1;
    vectors++;
    if (int'(mem_raddr) !== expv) begin
      miscompares++;
      $display("FAIL %s raddr(%0d,%0d): got %0d required %0d", name, r, c, mem_raddr, expv);
    end
  endtask

  task automatic test_reset();
    int rel, n, bad, rdy_cyc;
    rst = 1'b1;
    key_valid = 1'b0;
    repeat (3) step();
    vectors++;
    if (mem_we !== 1'b0 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: mem_we=%b key_ready=%b required 0 0", mem_we, key_ready);
    end
    vectors++;
    if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL reset cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    clear_logs();
    mdl_pos = 0;
    mdl_top = 0;
    rel = cyc;
    rst = 1'b0;
    n = 0;
    while (key_ready !== 1'b1 && n < TOTAL + 100) begin step(); n++; end
    rdy_cyc = cyc;
    vectors++;
    if (key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL init ready_timeout: key_ready=%b required 1", key_ready);
    end
    vectors++;
    bad = 0;
    if (obs_addr.size() != TOTAL) bad = 1;
    else for (int i = 0; i < TOTAL; i++)
      if (obs_addr[i] != i || obs_data[i] != 32 || obs_cyc[i] != rel + 1 + i) bad++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL init writes: got %0d writes, %0d bad, first at cycle %0d; required %0d consecutive blanks from cycle %0d",
               obs_addr.size(), bad, (obs_cyc.size() > 0) ? obs_cyc[0] : -1, TOTAL, rel + 1);
    end
    vectors++;
    if (rdy_cyc != rel + 1 + TOTAL) begin
      miscompares++;
      $display("FAIL init ready_cycle: got %0d required %0d", rdy_cyc - rel, 1 + TOTAL);
    end
    check_raddr(0, 0, 0, "init");
  endtask

  task automatic test_print_a();
    send_key(8'h41, "print_A");
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] != 0 || obs_data[0] != 8'h41) begin
      miscompares++;
      $display("FAIL print_A direct: got %0d writes required 1 write of 41 at 0", obs_addr.size());
    end
  endtask

  task automatic test_wrap();
    while (mdl_pos < COLS - 1) send_key($urandom_range(32, 126), "fill_row0");
    send_key(8'h42, "wrap_B");
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] != 69 || cur_row !== 5'd1 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL wrap_B direct: writes=%0d cursor (%0d,%0d) required 1 write at 69, cursor (1,0)",
               obs_addr.size(), cur_row, cur_col);
    end
    send_key(8'h0D, "newline");
  endtask

  task automatic test_scroll();
    while (mdl_pos / COLS < ROWS - 1) send_key(8'h0D, "nl_to_bottom");
    for (int i = 0; i < 5; i++) send_key($urandom_range(32, 126), "bottom_chars");
    send_key(8'h0D, "scroll_nl");
    check_raddr(0, 0, 70, "scroll");
    check_raddr(29, 0, 0, "scroll");
    check_raddr(30, 0, 0, "scroll_row_oob");
    check_raddr(3, 70, 0, "scroll_col_oob");
  endtask

  task automatic test_backspace();
    test_reset();
    send_key(8'h0D, "bs_nl");
    send_key(8'h08, "bs_row_wrap");
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] != 69 || obs_data[0] != 32) begin
      miscompares++;
      $display("FAIL bs_row_wrap direct: writes=%0d required 1 blank at 69", obs_addr.size());
    end
    while (mdl_pos > 0) send_key(8'h08, "bs_run");
    send_key(8'h08, "bs_origin");
    send_key(8'h01, "ignored_01");
    send_key(8'hC3, "ignored_c3");
  endtask

  task automatic test_random();
    int r, code;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      code = $urandom_range(32, 126);
      else if (r < 85) code = 13;
      else if (r < 95) code = 8;
      else begin
        code = $urandom_range(0, 255);
        if ((code >= 32 && code <= 126) || code == 8 || code == 13) code = 127;
      end
      send_key(code, "random");
      if (k % 8 == 0) begin
        int rr, cc;
        rr = $urandom_range(0, 31);
        cc = $urandom_range(0, 127);
        check_raddr(rr, cc, (rr < ROWS && cc < COLS) ? mdl_phys(rr, cc) : 0, "random");
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int n, bad, base;
    while (mdl_pos / COLS < ROWS - 1) send_key(8'h0D, "mc_nl");
    send_key(8'h58, "mc_char");
    base = mdl_top * COLS;
    clear_logs();
    key_valid = 1'b1;
    key_ascii = 8'h0D;
    step();
    key_valid = 1'b0;
    n = 0;
    while (obs_addr.size() < 30 && n < 200) begin step(); n++; end
    rst = 1'b1;
    vectors++;
    bad = 0;
    if (obs_addr.size() < 30) bad = 1;
    else for (int i = 0; i < 30; i++) if (obs_addr[i] != base + i || obs_data[i] != 32) bad++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mid_clear writes: got %0d writes, %0d bad, required 30 blanks from %0d",
               obs_addr.size(), bad, base);
    end
    step();
    vectors++;
    if (cur_row !== 5'd0 || cur_col !== 7'd0 || mem_we !== 1'b0 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear reset: cursor (%0d,%0d) mem_we=%b key_ready=%b required (0,0) 0 0",
               cur_row, cur_col, mem_we, key_ready);
    end
    test_reset();
    check_raddr(29, 0, 2030, "mid_clear_top");
    check_raddr(1, 5, 75, "mid_clear_top");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) send_key($urandom_range(32, 126), "b2b");
    send_key(8'h08, "b2b_bs");
    send_key(8'h0D, "b2b_nl");
  endtask

  initial begin
    test_reset();
    test_print_a();
    test_wrap();
    test_scroll();
    test_backspace();
    test_random();
    test_back_to_back();
    test_rst_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_buf_ctrl.md
TEXT_BUF_CTRL -- requirements
Module: text_buf_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 70, characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, text rows on screen.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  keyboard side offers key_ascii.
REQ-006 SHALL have port key_ascii  input  8  ASCII code offered.
REQ-007 SHALL have port key_ready  output  1  controller can accept a code this cycle.
REQ-008 SHALL have port mem_we  output  1  write strobe to character RAM.
REQ-009 SHALL have port mem_waddr  output  12  write address, phys_row*COLS + col.
REQ-010 SHALL have port mem_wdata  output  8  character written.
REQ-011 SHALL have port rd_row  input  5  logical row requested by display side.
REQ-012 SHALL have port rd_col  input  7  column requested by display side.
REQ-013 SHALL have port mem_raddr  output  12  translated read address, combinational.
REQ-014 SHALL have ports cur_row  output  5  and cur_col  output  7  logical cursor position.

Function
REQ-015 SHALL hold states INIT, IDLE, WRITE, CLEAR; mem_we, mem_waddr, mem_wdata, key_ready, cursor registered.
REQ-016 SHALL transfer a code only on a cycle where key_valid and key_ready are both 1; key_ready SHALL be 1 only in IDLE.
REQ-017 SHALL treat 0x20-0x7E as printable, 0x0D as newline, 0x08 as backspace; any other code accepted and discarded, no state change.
REQ-018 Printable: cycle after accept, mem_we=1 at (cur_row, cur_col) with the code; cursor advances that same edge.
REQ-019 Cursor advance: col+1; at col COLS-1 -> col 0, row+1; at row ROWS-1 -> scroll (REQ-021).
REQ-020 Newline: col 0, row+1 one cycle after accept, no write; at row ROWS-1 -> scroll.
REQ-021 Scroll: enter CLEAR, write 0x20 to physical row top_row, cols 0..COLS-1, one per cycle; after last write top_row = (top_row+1) mod ROWS, cursor = (ROWS-1, 0), return to IDLE.
REQ-022 Backspace: col>0 -> col-1, write 0x20 there; col 0, row>0 -> (row-1, COLS-1), write 0x20; at (0,0) no write, no move; write one cycle after accept.
REQ-023 Physical row SHALL be (logical row + top_row) mod ROWS, computed without overflow for all inputs in range.
REQ-024 mem_raddr SHALL equal ((rd_row+top_row) mod ROWS)*COLS + rd_col; rd_row>=ROWS or rd_col>=COLS SHALL give address 0.
REQ-025 mem_we SHALL be 0 in every cycle not named in REQ-018/021/022/027; key_ready SHALL be 0 whenever mem_we is 1.
REQ-026 Total addresses SHALL not exceed 4096; ROWS*COLS = 2100 by default.

Reset
REQ-027 On rst: cursor (0,0), top_row 0, mem_we 0, key_ready 0, state INIT; INIT writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, starting the first cycle after rst falls.
REQ-028 After the last INIT write, state SHALL be IDLE and key_ready 1 on the next cycle.
REQ-029 rst asserted in any state (mid-CLEAR, mid-INIT) SHALL abort it and restart INIT; an in-flight accepted code SHALL be dropped.

Verification
REQ-030 Reset release -> 2100 writes of 0x20, addr 0..2099 consecutive, key_ready=1 the cycle after addr 2099.
REQ-031 Send 'A' (0x41) at (0,0) -> mem_we, waddr 0, wdata 0x41 next cycle; cursor (0,1).
REQ-032 Cursor (0,69), send 0x42 -> waddr 69; cursor (1,0); 0x0D then gives (2,0), no write.
REQ-033 Cursor (29,5), send 0x0D -> 70 writes of 0x20 at addr 0..69, key_ready low throughout, then top_row 1, cursor (29,0); rd_row 0, rd_col 0 -> mem_raddr 70; rd_row 29 -> mem_raddr 0.
REQ-034 Cursor (1,0), send 0x08 -> write 0x20 at logical (0,69) i.e. waddr 69 (top_row 0), cursor (0,69); at (0,0) 0x08 -> no write; 0x01 -> accepted, ignored.
REQ-035 Assert rst mid-CLEAR (after 30 writes) -> INIT restarts at addr 0, cursor (0,0), top_row 0.
